count_alarm: RTL and testbench

Programmable alarm stage that consumes the free-running 32-bit `count` produced by `simple_counter` and raises single-cycle `alarm` pulses when the count reaches a configured target. It supports one-shot and periodic modes. It sits directly downstream of the counter and feeds event consumers such as interrupt logic and schedulers. Target comparison is wrap-aware, so alarms stay correct across the 2^32 rollover and across counter resets.

---
 rtl/count_alarm_pkg.sv | 12 +
 rtl/count_reached.sv | 18 +
 rtl/count_alarm.sv | 114 +++++++++++
 tb/tb_count_alarm.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/count_alarm_pkg.sv
// Shared types and default widths for the count_alarm block.
package count_alarm_pkg;

    localparam int WIDTH  = 32;
    localparam int FCNT_W = 16;

    typedef enum logic {
        ALARM_IDLE  = 1'b0,
        ALARM_ARMED = 1'b1
    } alarm_state_e;

endpackage

// File: rtl/count_reached.sv
// Wrap-aware "count has reached target" compare: the target counts as reached
// when it lies at most 2^(W-1)-1 behind count, modulo 2^W.
module count_reached #(
    parameter int W = 32
) (
    input  logic [W-1:0] count,
    input  logic [W-1:0] target,
    output logic         hit
);

    logic [W-1:0] diff;

    always_comb begin
        diff = count - target;
        hit  = ~diff[W-1];
    end

endmodule

// File: rtl/count_alarm.sv
// Programmable one-shot / periodic alarm on a free-running counter. It emits a
// registered single-cycle pulse per fire and keeps a saturating fire count.
module count_alarm #(
    parameter int WIDTH  = count_alarm_pkg::WIDTH,
    parameter int FCNT_W = count_alarm_pkg::FCNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [WIDTH-1:0]  cfg_target,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic              cancel,
    output logic              alarm,
    output logic              armed,
    output logic [FCNT_W-1:0] fire_cnt,
    output logic              overrun
);

    import count_alarm_pkg::*;

    alarm_state_e      state_q, state_d;
    logic [WIDTH-1:0]  target_q, target_d;
    logic [WIDTH-1:0]  period_q, period_d;
    logic              alarm_q, alarm_d;
    logic [FCNT_W-1:0] fire_cnt_q, fire_cnt_d;
    logic              overrun_q, overrun_d;

    logic [WIDTH-1:0]  reload_target;
    logic              hit;
    logic              reload_hit;

    assign reload_target = target_q + period_q;

    count_reached #(.W(WIDTH)) u_hit (
        .count  (count),
        .target (target_q),
        .hit    (hit)
    );

    // Checks whether the reloaded target is already behind the current count.
    count_reached #(.W(WIDTH)) u_reload_hit (
        .count  (count),
        .target (reload_target),
        .hit    (reload_hit)
    );

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        period_d   = period_q;
        alarm_d    = 1'b0;
        fire_cnt_d = fire_cnt_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            ALARM_IDLE: begin
                if (cfg_valid) begin
                    state_d    = ALARM_ARMED;
                    target_d   = cfg_target;
                    period_d   = cfg_period;
                    fire_cnt_d = '0;
                    overrun_d  = 1'b0;
                end
            end
            ALARM_ARMED: begin
                // cancel takes priority over a hit sampled on the same edge
                if (cancel) begin
                    state_d = ALARM_IDLE;
                end else if (hit) begin
                    alarm_d = 1'b1;
                    if (fire_cnt_q != {FCNT_W{1'b1}}) begin
                        fire_cnt_d = fire_cnt_q + FCNT_W'(1);
                    end
                    if (period_q == '0) begin
                        state_d = ALARM_IDLE;
                    end else begin
                        target_d = reload_target;
                        if (reload_hit) begin
                            overrun_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ALARM_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ALARM_IDLE;
            target_q   <= '0;
            period_q   <= '0;
            alarm_q    <= 1'b0;
            fire_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            period_q   <= period_d;
            alarm_q    <= alarm_d;
            fire_cnt_q <= fire_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    assign cfg_ready = (state_q == ALARM_IDLE);
    assign armed     = (state_q == ALARM_ARMED);
    assign alarm     = alarm_q;
    assign fire_cnt  = fire_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_count_alarm.sv
// Scoreboard bench for count_alarm: directed scenarios plus random traffic,
// checked cycle by cycle against a behavioural model of the alarm rules.
module tb_count_alarm;

    localparam int W    = 32;
    localparam int FW   = 4;
    localparam int FMAX = (1 << FW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  count;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_target;
    logic [W-1:0]  cfg_period;
    logic          cancel;
    logic          alarm;
    logic          armed;
    logic [FW-1:0] fire_cnt;
    logic          overrun;

    always #5 clk = ~clk;

    count_alarm #(.WIDTH(W), .FCNT_W(FW)) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_target (cfg_target),
        .cfg_period (cfg_period),
        .cancel     (cancel),
        .alarm      (alarm),
        .armed      (armed),
        .fire_cnt   (fire_cnt),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic          alarm;
        logic          armed;
        logic          cfg_ready;
        logic [FW-1:0] fire;
        logic          overrun;
    } obs_t;

    obs_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model: alarm rules evaluated directly, one call per clock edge.
    bit       m_armed = 0;
    bit [W-1:0] m_tgt = '0;
    bit [W-1:0] m_per = '0;
    int       m_fire  = 0;
    bit       m_ovr   = 0;

    function automatic bit reached(input bit [W-1:0] c, input bit [W-1:0] t);
        bit [W-1:0] behind;
        behind = c - t;
        return behind < 32'h8000_0000;
    endfunction

    task automatic apply(input logic r, input logic cv, input logic cn,
                         input logic [W-1:0] cnt, input logic [W-1:0] tg,
                         input logic [W-1:0] pd);
        obs_t e;
        bit   m_alarm;
        @(negedge clk);
        rst = r; cfg_valid = cv; cancel = cn;
        count = cnt; cfg_target = tg; cfg_period = pd;
        m_alarm = 0;
        if (!r) begin
            m_armed = 0; m_tgt = '0; m_per = '0; m_fire = 0; m_ovr = 0;
        end else if (!m_armed) begin
            if (cv) begin
                m_armed = 1; m_tgt = tg; m_per = pd; m_fire = 0; m_ovr = 0;
            end
        end else if (cn) begin
            m_armed = 0;
        end else if (reached(cnt, m_tgt)) begin
            m_alarm = 1;
            if (m_fire < FMAX) m_fire = m_fire + 1;
            if (m_per == 0) begin
                m_armed = 0;
            end else begin
                m_tgt = m_tgt + m_per;
                if (reached(cnt, m_tgt)) m_ovr = 1;
            end
        end
        e.alarm     = m_alarm;
        e.armed     = m_armed;
        e.cfg_ready = !m_armed;
        e.fire      = FW'(m_fire);
        e.overrun   = m_ovr;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per edge, checked just after that edge.
    obs_t mon_e, mon_g;
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = '{alarm, armed, cfg_ready, fire_cnt, overrun};
            vectors++;
            if (mon_g !== mon_e) begin
                miscompares++;
                $display("FAIL outputs t=%0t count=%h got alarm=%b armed=%b rdy=%b fire=%0d ovr=%b exp alarm=%b armed=%b rdy=%b fire=%0d ovr=%b",
                         $time, count, mon_g.alarm, mon_g.armed, mon_g.cfg_ready, mon_g.fire, mon_g.overrun,
                         mon_e.alarm, mon_e.armed, mon_e.cfg_ready, mon_e.fire, mon_e.overrun);
            end
        end
    end

    logic [W-1:0] cnt;

    task automatic tick(input logic cv, input logic cn, input logic [W-1:0] tg, input logic [W-1:0] pd);
        apply(1'b1, cv, cn, cnt, tg, pd);
        cnt = cnt + 1;
    endtask

    initial begin
        int r;
        logic [W-1:0] tg, pd;
        logic cv, cn, rr;
        rst = 1'b0; cfg_valid = 1'b0; cancel = 1'b0;
        count = '0; cfg_target = '0; cfg_period = '0;
        cnt = '0;

        repeat (2) apply(1'b0, 1'b0, 1'b0, '0, '0, '0);

        // One-shot
        cnt = 5;  tick(1, 0, 20, 0);   repeat (25) tick(0, 0, 0, 0);
        // Periodic
        cnt = 0;  tick(1, 0, 10, 8);   repeat (40) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        // Wrap across rollover
        cnt = 32'hFFFF_FFF0; tick(1, 0, 4, 0); repeat (30) tick(0, 0, 0, 0);
        // Past target, then overrun catch-up
        cnt = 100; tick(1, 0, 50, 0);  repeat (5) tick(0, 0, 0, 0);
        cnt = 40;  tick(1, 0, 10, 2);  repeat (40) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        // Fire-count saturation
        cnt = 0;   tick(1, 0, 0, 1);   repeat (25) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        // Cancel on the hit edge
        cnt = 0;   tick(1, 0, 5, 0);   repeat (4) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);              repeat (5) tick(0, 0, 0, 0);
        // Reset mid-operation with the target reached
        cnt = 200; tick(1, 0, 201, 1); repeat (3) tick(0, 0, 0, 0);
        apply(1'b0, 1'b1, 1'b0, cnt, 0, 0); cnt = cnt + 1;
        repeat (5) tick(0, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 85)      cnt = cnt + 1;
            else if (r >= 92) cnt = $urandom;
            r = $urandom_range(0, 99);
            tg = (r < 80) ? cnt + W'($urandom_range(0, 60)) - W'(20) : W'($urandom);
            r = $urandom_range(0, 99);
            pd = (r < 30) ? '0 : (r < 85) ? W'($urandom_range(1, 12)) : W'($urandom);
            cv = ($urandom_range(0, 99) < 20);
            cn = ($urandom_range(0, 99) < 4);
            rr = ($urandom_range(0, 99) >= 1);
            apply(rr, cv, cn, cnt, tg, pd);
        end

        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        @(posedge clk); #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
